// File: rtl/spi_adc_responder.sv
// spi_adc_responder
// Stand-in for the serial ADC on the board side of the lab2 SPI link. It
// watches the reader's chip select (active low) and serial clock and shifts
// out a frame of FRAME_BITS bits, MSB first. The frame is made of leading
// zeros followed by a DATA_BITS-wide sample from the hold register.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   cs           chip select from the reader, active low, asynchronous
//   sck          serial clock from the reader, idles high, asynchronous
//   sdo          serial data to the reader, changes after sck falling edges
//   sample_in    next sample value
//   sample_valid loads sample_in into the hold register
//   busy         high while a frame is being shifted
//   frame_done   one-cycle pulse when a complete frame has been sent
//   frame_abort  one-cycle pulse when cs rises mid-frame
//   frame_count  completed frames, modulo 256
module spi_adc_responder #(
    parameter int DATA_BITS   = 12,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 sck,
    output logic                 sdo,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [7:0]           frame_count
);

    localparam int IDX_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Bits [SYNC_STAGES-1:0] are the synchronizer, the top bit is the
    // extra flop holding the previous synchronized value for edge detection.
    logic [SYNC_STAGES:0] cs_pipe_reg;
    logic [SYNC_STAGES:0] sck_pipe_reg;
    logic                 cs_fall;
    logic                 cs_rise;
    logic                 sck_fall;

    logic [DATA_BITS-1:0]  hold_reg;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [FRAME_BITS-1:0] frame_next;
    logic [IDX_W-1:0]      bit_idx_reg;
    logic [IDX_W-1:0]      bit_idx_next;
    logic                  sdo_reg;
    logic                  sdo_next;
    logic                  done_reg;
    logic                  done_next;
    logic                  abort_reg;
    logic                  abort_next;
    logic [7:0]            count_reg;
    logic [7:0]            count_next;

    assign cs_fall  =  cs_pipe_reg[SYNC_STAGES]  & ~cs_pipe_reg[SYNC_STAGES-1];
    assign cs_rise  = ~cs_pipe_reg[SYNC_STAGES]  &  cs_pipe_reg[SYNC_STAGES-1];
    assign sck_fall =  sck_pipe_reg[SYNC_STAGES] & ~sck_pipe_reg[SYNC_STAGES-1];

    // State and datapath registers. The synchronizers preset to the idle
    // level (high) so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cs_pipe_reg  <= '1;
            sck_pipe_reg <= '1;
            hold_reg     <= '0;
            frame_reg    <= '0;
            bit_idx_reg  <= '0;
            sdo_reg      <= 1'b0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cs_pipe_reg  <= {cs_pipe_reg[SYNC_STAGES-1:0], cs};
            sck_pipe_reg <= {sck_pipe_reg[SYNC_STAGES-1:0], sck};
            // The frame snapshot below reads the old hold value, so a load
            // coinciding with the cs fall is kept for the next frame.
            if (sample_valid) begin
                hold_reg <= sample_in;
            end
            frame_reg    <= frame_next;
            bit_idx_reg  <= bit_idx_next;
            sdo_reg      <= sdo_next;
            done_reg     <= done_next;
            abort_reg    <= abort_next;
            count_reg    <= count_next;
        end
    end

    // Next-state logic. A cs edge wins over an sck edge in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end else if (sck_fall && (bit_idx_reg == '0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cs_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        frame_next   = frame_reg;
        bit_idx_next = bit_idx_reg;
        sdo_next     = sdo_reg;
        done_next    = 1'b0;
        abort_next   = 1'b0;
        count_next   = count_reg;
        case (state_reg)
            ST_IDLE: begin
                sdo_next = 1'b0;
                if (cs_fall) begin
                    frame_next   = FRAME_BITS'(hold_reg);
                    bit_idx_next = IDX_W'(FRAME_BITS - 1);
                    sdo_next     = frame_next[FRAME_BITS-1];
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    sdo_next   = 1'b0;
                    abort_next = 1'b1;
                end else if (sck_fall) begin
                    if (bit_idx_reg == '0) begin
                        // Falling edge number FRAME_BITS: the last bit has
                        // been presented for a full sck period.
                        sdo_next   = 1'b0;
                        done_next  = 1'b1;
                        count_next = count_reg + 8'd1;
                    end else begin
                        bit_idx_next = bit_idx_reg - IDX_W'(1);
                        sdo_next     = frame_reg[bit_idx_next];
                    end
                end
            end
            ST_DONE: begin
                sdo_next = 1'b0;
            end
            default: begin
                sdo_next = 1'b0;
            end
        endcase
    end

    assign sdo         = sdo_reg;
    assign busy        = (state_reg == ST_SHIFT);
    assign frame_done  = done_reg;
    assign frame_abort = abort_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: a reader model drives cs/sck, captures the
// serial frame and compares against frames derived from the sample values.
module tb_spi_adc_responder;

    localparam int DB = 12;
    localparam int FB = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          sck;
    logic          sdo;
    logic [DB-1:0] sample_in;
    logic          sample_valid;
    logic          busy;
    logic          frame_done;
    logic          frame_abort;
    logic [7:0]    frame_count;

    spi_adc_responder #(
        .DATA_BITS   (DB),
        .FRAME_BITS  (FB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .sck          (sck),
        .sdo          (sdo),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pulse monitors: count cycles each pulse is high, and overlaps.
    int done_cnt  = 0;
    int abort_cnt = 0;
    int both_cnt  = 0;
    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
        if (frame_done === 1'b1 && frame_abort === 1'b1) both_cnt++;
    end

    // Reference state: what the hold register and frame counter should be.
    logic [DB-1:0] model_hold;
    logic [7:0]    model_count;

    typedef struct {
        bit            load_en;
        logic [DB-1:0] sample;
        int            n_falls;
        bit            mid_en;
        logic [DB-1:0] mid_val;
        logic [FB-1:0] exp_frame;
        bit            exp_done;
        bit            exp_abort;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DB-1:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        model_hold   = v;
    endtask

    // One cs window with n_falls sck periods. sdo is captured just before
    // each falling edge, i.e. the value the reader saw on the preceding
    // rising edge (the idle-high level counts for the MSB).
    task automatic run_frame(input string tag, input int n_falls, input int half,
                             input bit mid_en, input logic [DB-1:0] mid_val, input int mid_at,
                             input logic [FB-1:0] exp_frame, input bit exp_done, input bit exp_abort);
        int          d0;
        int          a0;
        logic [31:0] cap;
        logic [31:0] exp_cap;
        d0  = done_cnt;
        a0  = abort_cnt;
        cap = '0;
        cs  = 1'b0;
        step(2 * SS + 2);
        check({tag, " busy_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < n_falls; i++) begin
            cap = {cap[30:0], sdo};
            sck = 1'b0;
            step(half);
            if (mid_en && i == mid_at) load(mid_val);
            sck = 1'b1;
            step(half);
        end
        step(4);
        check({tag, " busy_end"}, 32'(busy), (n_falls < FB) ? 32'd1 : 32'd0);
        cs = 1'b1;
        step(SS + 1);
        check({tag, " sdo_after_cs"}, 32'(sdo), 32'd0);
        step(SS + 2);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        exp_cap = (n_falls <= FB) ? (32'(exp_frame) >> (FB - n_falls))
                                  : (32'(exp_frame) << (n_falls - FB));
        check({tag, " bits"}, cap, exp_cap);
        check({tag, " done"}, 32'(done_cnt - d0), 32'(exp_done));
        check({tag, " abort"}, 32'(abort_cnt - a0), 32'(exp_abort));
        if (exp_done) model_count = model_count + 8'd1;
        check({tag, " count"}, 32'(frame_count), 32'(model_count));
        $display("frame %s: falls=%0d captured=%0h expected=%0h count=%0d",
                 tag, n_falls, cap, exp_cap, frame_count);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            n;
        int            half;
        bit            mid_en;
        int            mid_at;
        logic [DB-1:0] mid_val;
        logic [FB-1:0] exp_f;
        int            a0;
        int            d0;

        rst          = 1'b1;
        cs           = 1'b1;
        sck          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_hold   = '0;
        model_count  = '0;

        //            load  sample  falls mid  mid_val exp_frame done abort
        vecs[0] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 12'hEE0, 16, 1'b0, 12'h000, 16'h0EE0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 12'hABC,  7, 1'b0, 12'h000, 16'h0ABC, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0ABC, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 12'h123, 16, 1'b1, 12'hFFF, 16'h0123, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 16, 1'b0, 12'h000, 16'h0FFF, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 12'h001, 20, 1'b0, 12'h000, 16'h0001, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 12'h800, 16, 1'b0, 12'h000, 16'h0800, 1'b1, 1'b0};

        // Reset state.
        step(4);
        check("rst sdo", 32'(sdo), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(frame_done), 32'd0);
        check("rst abort", 32'(frame_abort), 32'd0);
        check("rst count", 32'(frame_count), 32'd0);
        rst = 1'b0;
        step(6);
        check("rst no_pulse", 32'(done_cnt + abort_cnt), 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].load_en) load(vecs[i].sample);
            run_frame($sformatf("vec%0d", i), vecs[i].n_falls, 4, vecs[i].mid_en,
                      vecs[i].mid_val, 3, vecs[i].exp_frame, vecs[i].exp_done, vecs[i].exp_abort);
        end

        // Randomized frames against the hold/count model.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) != 0) load(DB'($urandom));
            exp_f   = FB'(model_hold);
            n       = $urandom_range(1, 20);
            half    = $urandom_range(SS + 2, 7);
            mid_en  = ($urandom_range(0, 1) == 1);
            mid_at  = $urandom_range(0, n - 1);
            mid_val = DB'($urandom);
            run_frame($sformatf("rnd%0d", r), n, half, mid_en, mid_val, mid_at,
                      exp_f, (n >= FB), (n < FB));
        end

        // Counter wrap: 256 complete frames from a fresh reset.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
        model_hold  = '0;
        model_count = '0;
        for (int f = 0; f < 256; f++) begin
            load(DB'(f * 37 + 5));
            run_frame($sformatf("wrap%0d", f), FB, SS + 2, 1'b0, '0, 0,
                      FB'(model_hold), 1'b1, 1'b0);
        end
        check("wrap count_zero", 32'(frame_count), 32'd0);

        // Reset in the middle of a frame.
        load(12'h5AA);
        a0 = abort_cnt;
        d0 = done_cnt;
        cs = 1'b0;
        step(2 * SS + 2);
        for (int i = 0; i < 5; i++) begin
            sck = 1'b0;
            step(4);
            sck = 1'b1;
            step(4);
        end
        rst = 1'b1;
        step(1);
        check("midrst sdo", 32'(sdo), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(frame_done), 32'd0);
        check("midrst abort", 32'(frame_abort), 32'd0);
        check("midrst count", 32'(frame_count), 32'd0);
        cs  = 1'b1;
        sck = 1'b1;
        step(4);
        rst = 1'b0;
        step(6);
        check("midrst no_pulse", 32'((abort_cnt - a0) + (done_cnt - d0)), 32'd0);
        model_hold  = '0;
        model_count = '0;
        load(12'h3C5);
        run_frame("post_rst", FB, 5, 1'b0, '0, 0, 16'h03C5, 1'b1, 1'b0);

        check("never_both", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable model of the serial ADC that the lab2 SPI reader talks to: the responder end of the 16-bit chip-select/serial-clock/serial-data link. It watches the reader's `cs` (active low) and `sck`, and shifts a 16-bit frame out on `sdo`, MSB first. The frame is 4 leading zeros followed by a 12-bit sample. It sits on the board side of the link, in place of the physical converter, so the reader and comparator can be exercised in hardware and in simulation with known sample values.

## Interface
- `DATA_BITS`, default 12: sample width.
- `FRAME_BITS`, default 16: bits per frame. Leading zeros = `FRAME_BITS - DATA_BITS` (must be ≥ 0).
- `SYNC_STAGES`, default 2: synchronizer depth on `cs` and `sck`.
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `cs`, input, 1: chip select from the reader, active low. Asynchronous to `clk`.
- `sck`, input, 1: serial clock from the reader. Asynchronous to `clk`; idles high.
- `sdo`, output, 1: serial data to the reader.
- `sample_in`, input, `DATA_BITS`: next sample value.
- `sample_valid`, input, 1: loads `sample_in` into the hold register.
- `busy`, output, 1: high while a frame is in progress (state SHIFT).
- `frame_done`, output, 1: one-cycle pulse when a full frame has been sent.
- `frame_abort`, output, 1: one-cycle pulse when `cs` rises mid-frame.
- `frame_count`, output, 8: number of completed frames, modulo 256.

## Operation
- **Input conditioning.** `cs` and `sck` each pass through `SYNC_STAGES` flops, plus one more flop for edge detection. Edges are taken only from synchronized values.
- **Hold register.**
  - Loads `sample_in` on any cycle with `sample_valid`=1, in any state.
  - The frame register snapshots it at the `cs` falling edge, so updates during a frame do not affect that frame.
- **State IDLE.**
  - `sdo`=0 and `busy`=0.
  - `sck` edges are ignored.
  - A `cs` falling edge loads frame = {zeros, hold}, sets bit index = `FRAME_BITS-1`, drives `sdo` = frame MSB, and moves to SHIFT.
- **State SHIFT.**
  - On each synchronized `sck` falling edge: decrement the bit index and drive `sdo` = frame[index].
  - On the `FRAME_BITS`-th falling edge: `sdo`=0, pulse `frame_done`, increment `frame_count`, move to DONE.
  - A `cs` rising edge: `sdo`=0, pulse `frame_abort`, move to IDLE. No count change.
- **State DONE.**
  - `sdo`=0 and `sck` edges are ignored.
  - A `cs` rising edge moves to IDLE.
- **Simultaneous events.**
  - A `cs` edge detected in the same cycle as an `sck` edge takes priority; the `sck` edge is discarded.
  - `sample_valid` coinciding with a `cs` fall: the frame takes the old hold value, and the new value is held for the next frame.
- **`frame_count`** wraps from 255 to 0.
- **Reset.**
  - State = IDLE.
  - `sdo`, `busy`, `frame_done`, `frame_abort`, `frame_count` and the hold register all = 0.
  - Synchronizer flops preset to `cs`=1, `sck`=1, so leaving reset produces no spurious edge.
  - Reset mid-frame abandons the frame with no `frame_abort` pulse.

## Timing
- Latency from a pin edge to `sdo` change, `busy` change or a pulse: `SYNC_STAGES`+1 `clk` cycles (3 by default). It is constant; jitter is at most 1 cycle, from asynchronous sampling.
- `sdo` is valid from a falling `sck` edge plus 3 cycles until the next falling edge plus 3 cycles. The reader samples on the rising `sck` edge.
- `sck` high and low times must each be ≥ `SYNC_STAGES`+2 `clk` cycles. Edges closer than that are undefined.
- The `cs` falling edge must lead the first `sck` fall by ≥ `SYNC_STAGES`+2 cycles.
- `frame_done` and `frame_abort` are exactly 1 cycle wide and are never asserted together.
- `busy` rises in the cycle the MSB is driven and falls in the cycle `frame_done` or `frame_abort` pulses.

## Test plan
- **Basic frame.** Reset, `sample_valid` with `sample_in`=12'hEE0, `cs` low, 16 `sck` periods of 8 `clk` cycles each, `cs` high. Required:
  - bits captured on rising `sck` = 16'h0EE0;
  - `frame_done` pulses once;
  - `frame_count`=1;
  - `busy` spans the frame.
- **Abort.** `cs` rises after 7 `sck` falls. Required:
  - `frame_abort` pulses once and `frame_done` stays 0;
  - `frame_count` unchanged;
  - `sdo`=0 within 3 cycles;
  - the next full frame is correct.
- **Mid-frame update.** `sample_valid` with 12'hFFF during a 12'h123 frame. Required: this frame is 16'h0123 and the next frame is 16'h0FFF.
- **Extra clocks.** 20 `sck` periods in one `cs` window. Required:
  - `sdo` stays 0 after bit 0;
  - one `frame_done`;
  - state holds in DONE until `cs` rises.
- **Wrap and reset.** 256 frames: `frame_count` wraps to 0. Then reset asserted mid-frame: all outputs 0 next cycle, no pulses, and the next frame is correct.
